edge_regenerator: RTL

- Inverse of the edge-detector path: accepts single-cycle rise/fall request pulses and rebuilds a clean level signal `sig_out`.
- Enforces a minimum dwell time per level, queues one early request and flags illegal requests.
- Sits between control logic that emits edge events and a level-sensitive downstream consumer (enable line, strobe, external pin driver).

---
 rtl/edge_regen_pkg.sv | 21 ++
 rtl/edge_regenerator_hold_timer.sv | 31 +++
 rtl/edge_regenerator.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/edge_regen_pkg.sv
// rtl/edge_regen_pkg.sv - shared state encoding, defaults and timer sizing for edge_regenerator
package edge_regen_pkg;

  typedef enum logic [1:0] {
    LOW_IDLE  = 2'd0,
    HIGH_HOLD = 2'd1,
    HIGH_IDLE = 2'd2,
    LOW_HOLD  = 2'd3
  } regen_state_t;

  localparam int MIN_HOLD_DEFAULT = 4;
  localparam int CNT_W_DEFAULT    = 16;

  // Dwell timer only ever holds MIN_HOLD-1 down to 0; keep at least one bit.
  function automatic int timer_width(input int min_hold);
    int w;
    w = $clog2(min_hold);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_regenerator_hold_timer.sv
// rtl/edge_regenerator_hold_timer.sv - load/decrement dwell counter with zero flag
module hold_timer
  import edge_regen_pkg::*;
#(
  parameter int MIN_HOLD = MIN_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int            TW       = timer_width(MIN_HOLD);
  localparam logic [TW-1:0] LOAD_VAL = TW'(MIN_HOLD - 1);

  logic [TW-1:0] count;

  // Load on hold entry, then count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/edge_regenerator.sv
// rtl/edge_regenerator.sv - rebuilds a level from rise/fall pulses with min dwell; EDGE_REGEN_STATS_EN adds transition counters
module edge_regenerator
  import edge_regen_pkg::*;
#(
  parameter int MIN_HOLD = MIN_HOLD_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rise_req,
  input  logic             fall_req,
  output logic             sig_out,
  output logic             busy,
  output logic             pending,
  output logic             err_pulse
`ifdef EDGE_REGEN_STATS_EN
  ,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] fall_count
`endif
);

  regen_state_t state;
  regen_state_t state_nxt;
  logic         pending_nxt;
  logic         timer_load;
  logic         timer_zero;
  logic         both_req;
  logic         rise_only;
  logic         fall_only;
  logic         sig_nxt;
  logic         busy_nxt;

  // A simultaneous rise+fall is an error and neither side is acted on.
  assign both_req  = rise_req & fall_req;
  assign rise_only = rise_req & ~fall_req;
  assign fall_only = fall_req & ~rise_req;

  hold_timer #(
    .MIN_HOLD (MIN_HOLD)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .zero (timer_zero)
  );

  // Next state, one-deep queue update and timer load.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    timer_load  = 1'b0;
    case (state)
      LOW_IDLE: begin
        if (rise_only) begin
          state_nxt  = HIGH_HOLD;
          timer_load = 1'b1;
        end
      end
      HIGH_IDLE: begin
        if (fall_only) begin
          state_nxt  = LOW_HOLD;
          timer_load = 1'b1;
        end
      end
      HIGH_HOLD: begin
        if (!timer_zero) begin
          if (fall_only) begin
            pending_nxt = 1'b1;
          end else if (rise_only) begin
            pending_nxt = 1'b0;
          end
        end else if ((pending && !rise_only) || fall_only) begin
          state_nxt   = LOW_HOLD;
          timer_load  = 1'b1;
          pending_nxt = 1'b0;
        end else begin
          state_nxt   = HIGH_IDLE;
          pending_nxt = 1'b0;
        end
      end
      LOW_HOLD: begin
        if (!timer_zero) begin
          if (rise_only) begin
            pending_nxt = 1'b1;
          end else if (fall_only) begin
            pending_nxt = 1'b0;
          end
        end else if ((pending && !fall_only) || rise_only) begin
          state_nxt   = HIGH_HOLD;
          timer_load  = 1'b1;
          pending_nxt = 1'b0;
        end else begin
          state_nxt   = LOW_IDLE;
          pending_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt   = LOW_IDLE;
        pending_nxt = 1'b0;
      end
    endcase
  end

  assign sig_nxt  = (state_nxt == HIGH_HOLD) || (state_nxt == HIGH_IDLE);
  assign busy_nxt = (state_nxt == HIGH_HOLD) || (state_nxt == LOW_HOLD);

  // State and registered outputs, decoded from the next state so sig_out moves one cycle after the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOW_IDLE;
      pending   <= 1'b0;
      sig_out   <= 1'b0;
      busy      <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      sig_out   <= sig_nxt;
      busy      <= busy_nxt;
      err_pulse <= both_req;
    end
  end

`ifdef EDGE_REGEN_STATS_EN
  // Saturating counts of real output transitions only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_count <= '0;
      fall_count <= '0;
    end else begin
      if (sig_nxt && !sig_out && (rise_count != '1)) begin
        rise_count <= rise_count + CNT_W'(1);
      end
      if (!sig_nxt && sig_out && (fall_count != '1)) begin
        fall_count <= fall_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule
